fp_ci_master: RTL

Initiator side of the Nios II multi-cycle custom-instruction handshake: clk_en, start, dataa/datab, n, done and result. It accepts FP operation requests on a valid/ready port and issues each one to a custom-instruction FP ALU slave. It waits for done, or times out and flushes the slave, and returns the result on a valid/ready response port. It sits between a DMA/stream sequencer and the FP ALU, so the ALU can be exercised without the CPU.

---
 rtl/fp_ci_pkg.sv | 22 ++
 rtl/fp_ci_master_if.sv | 39 +++
 rtl/fp_ci_timeout_timer.sv | 32 +++
 rtl/fp_ci_master.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fp_ci_pkg.sv
// fp_ci_pkg: shared definitions for the FP custom-instruction master and the
// FP ALU wrapper (opcodes, FSM state type, special IEEE-754 single words).
package fp_ci_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [31:0] FP_NAN     = 32'h7fffffff;
  localparam logic [31:0] FP_POS_INF = 32'h7f800000;
  localparam logic [31:0] FP_NEG_INF = 32'hff800000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FLUSH,
    ST_RESP
  } state_t;

endpackage

// File: rtl/fp_ci_master_if.sv
// fp_ci_master_if: bundles the request port, response port and the
// custom-instruction slave bus of fp_ci_master.
//   master modport : view of fp_ci_master itself
//   slave modport  : view of the surroundings (requester, consumer, FP ALU)
interface fp_ci_master_if;
  // request port
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_dataa;
  logic [31:0] req_datab;
  logic [1:0]  req_n;
  // response port
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  // custom-instruction slave bus
  logic        ci_clk_en;
  logic        ci_start;
  logic        ci_reset;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic [1:0]  ci_n;
  logic        ci_done;
  logic [31:0] ci_result;

  modport master (
    input  req_valid, req_dataa, req_datab, req_n, rsp_ready, ci_done, ci_result,
    output req_ready, rsp_valid, rsp_result, rsp_timeout,
           ci_clk_en, ci_start, ci_reset, ci_dataa, ci_datab, ci_n
  );

  modport slave (
    output req_valid, req_dataa, req_datab, req_n, rsp_ready, ci_done, ci_result,
    input  req_ready, rsp_valid, rsp_result, rsp_timeout,
           ci_clk_en, ci_start, ci_reset, ci_dataa, ci_datab, ci_n
  );

endinterface

// File: rtl/fp_ci_timeout_timer.sv
// fp_ci_timeout_timer: down-counter measuring cycles spent waiting for the
// slave. clear loads TIMEOUT_CYCLES-1; enable counts down; tc flags the last
// allowed wait cycle (count reached zero).
// Ports: clk, reset (sync, active-high), clear, enable, tc.
module fp_ci_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/fp_ci_master.sv
// fp_ci_master: issues FP operation requests to a multi-cycle custom-instruction
// FP ALU, waits for done (or times out and flushes the slave) and returns the
// result on a valid/ready response port.
// Ports: clk, reset (sync, active-high), bus (fp_ci_master_if.master),
//        busy (not idle), op_count (completed responses, wrapping),
//        timeout_count (timed-out ops, saturating).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; operands latched on acceptance
// ISSUE    | one-cycle start pulse to slave, timer loaded
// WAIT     | clock enabled, waiting for done or timer terminal count
// FLUSH    | one-cycle slave reset after a timeout
// RESP     | response presented until the consumer accepts it
module fp_ci_master
  import fp_ci_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NAN_VALUE      = FP_NAN
) (
  input  logic          clk,
  input  logic          reset,
  fp_ci_master_if.master bus,
  output logic          busy,
  output logic [15:0]   op_count,
  output logic [7:0]    timeout_count
);

  state_t state, state_next;
  logic   load_ops, take_done, take_timeout, rsp_fire;
  logic   timer_clear, timer_en, timer_tc;

  fp_ci_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    load_ops     = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    rsp_fire     = 1'b0;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          load_ops   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // done seen here belongs to a previous operation and is ignored
        timer_clear = 1'b1;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a timeout on the same cycle
        if (bus.ci_done) begin
          take_done  = 1'b1;
          state_next = ST_RESP;
        end else if (timer_tc) begin
          take_timeout = 1'b1;
          state_next   = ST_FLUSH;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_FLUSH: state_next = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state
  // they belong to without any combinational path to the slave.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ci_start    <= 1'b0;
      bus.ci_clk_en   <= 1'b0;
      bus.ci_dataa    <= '0;
      bus.ci_datab    <= '0;
      bus.ci_n        <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_result  <= '0;
      bus.rsp_timeout <= 1'b0;
      op_count        <= '0;
      timeout_count   <= '0;
    end else begin
      bus.ci_start  <= (state_next == ST_ISSUE);
      bus.ci_clk_en <= (state_next == ST_ISSUE) || (state_next == ST_WAIT) ||
                       (state_next == ST_FLUSH);
      bus.rsp_valid <= (state_next == ST_RESP);
      if (load_ops) begin
        bus.ci_dataa <= bus.req_dataa;
        bus.ci_datab <= bus.req_datab;
        bus.ci_n     <= bus.req_n;
      end
      if (take_done) begin
        bus.rsp_result  <= bus.ci_result;
        bus.rsp_timeout <= 1'b0;
      end
      if (take_timeout) begin
        bus.rsp_result  <= NAN_VALUE;
        bus.rsp_timeout <= 1'b1;
        if (timeout_count != 8'hff) timeout_count <= timeout_count + 8'd1;
      end
      if (rsp_fire) op_count <= op_count + 16'd1;
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.ci_reset  = reset || (state == ST_FLUSH);
  assign busy          = (state != ST_IDLE);

endmodule
